raster_cmd_processor: RTL and testbench

RASTER_CMD_PROCESSOR -- requirements
Module: raster_cmd_processor

---
 rtl/raster_cmd_processor.sv | 247 ++++++++++++++++++++++++
 tb/tb_raster_cmd_processor.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_cmd_processor.sv
// raster_cmd_processor: queued command engine driving framebuffer pixel
// writes (CLEAR / FILL_RECT) and palette updates (SET_PALETTE).
// Optional build macro RASTER_CLIP_EN: out-of-range FILL_RECT corners are
// clamped to the framebuffer edge instead of being rejected with an error.
module raster_cmd_processor #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12,
    parameter int CMD_FIFO_DEPTH = 4,
    localparam int XW = $clog2(RESOLUTION_X),
    localparam int YW = $clog2(RESOLUTION_Y),
    localparam int IW = $clog2(PALETTE_LENGTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [31:0]           control_i,
    output logic [31:0]           status_o,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [XW-1:0]         cmd_x0_i,
    input  logic [XW-1:0]         cmd_x1_i,
    input  logic [YW-1:0]         cmd_y0_i,
    input  logic [YW-1:0]         cmd_y1_i,
    input  logic [IW-1:0]         cmd_index_i,
    input  logic [COLOR_BITS-1:0] cmd_color_i,
    output logic [XW-1:0]         fb_wr_x_o,
    output logic [YW-1:0]         fb_wr_y_o,
    output logic [IW-1:0]         fb_wr_index_o,
    output logic                  fb_wr_en_o,
    input  logic                  fb_wr_ready_i,
    output logic [IW-1:0]         palette_wr_index_o,
    output logic [COLOR_BITS-1:0] palette_wr_color_o,
    output logic                  palette_wr_en_o
);

    localparam int AW = $clog2(CMD_FIFO_DEPTH);

    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_PAL   = 2'd3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RASTER  = 2'd1;
    localparam logic [1:0] S_PALETTE = 2'd2;

    localparam logic [XW-1:0] X_LAST   = XW'(RESOLUTION_X - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(RESOLUTION_Y - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(CMD_FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]            op;
        logic [XW-1:0]         x0;
        logic [XW-1:0]         x1;
        logic [YW-1:0]         y0;
        logic [YW-1:0]         y1;
        logic [IW-1:0]         idx;
        logic [COLOR_BITS-1:0] color;
    } cmd_t;

    cmd_t                  mem_q [CMD_FIFO_DEPTH];
    cmd_t                  cmd_in;
    cmd_t                  head;
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           count_q;
    logic                  full, abort, push, pop;

    logic [1:0]            state_q, state_d;
    logic [XW-1:0]         x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0]         y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [IW-1:0]         fill_q, fill_d, pal_idx_q, pal_idx_d;
    logic [COLOR_BITS-1:0] pal_col_q, pal_col_d;
    logic                  error_q, error_d, err_set;

    logic [XW-1:0]         rx0, rx1, rx_lo, rx_hi;
    logic [YW-1:0]         ry0, ry1, ry_lo, ry_hi;
    logic                  rect_oob;
    logic                  unused_ctrl;

    assign unused_ctrl = ^control_i[31:2];

    assign abort       = control_i[0];
    assign full        = (count_q == FULL_CNT);
    assign cmd_ready_o = reset_ni & ~full & ~abort;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign pop         = (state_q == S_IDLE) && (count_q != '0) && !abort;
    assign cmd_in      = {cmd_op_i, cmd_x0_i, cmd_x1_i, cmd_y0_i, cmd_y1_i,
                          cmd_index_i, cmd_color_i};
    assign head        = mem_q[rptr_q];

    // FIFO storage: write the accepted command at the tail
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= cmd_in;
    end

    // FIFO pointers and occupancy; abort flushes everything
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (abort) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // Normalise the head FILL_RECT: clamp or flag range, then order corners
    always_comb begin
        rx0      = head.x0;
        rx1      = head.x1;
        ry0      = head.y0;
        ry1      = head.y1;
        rect_oob = 1'b0;
`ifdef RASTER_CLIP_EN
        if (rx0 > X_LAST) rx0 = X_LAST;
        if (rx1 > X_LAST) rx1 = X_LAST;
        if (ry0 > Y_LAST) ry0 = Y_LAST;
        if (ry1 > Y_LAST) ry1 = Y_LAST;
`else
        rect_oob = (head.x0 > X_LAST) || (head.x1 > X_LAST) ||
                   (head.y0 > Y_LAST) || (head.y1 > Y_LAST);
`endif
        rx_lo = (rx0 < rx1) ? rx0 : rx1;
        rx_hi = (rx0 < rx1) ? rx1 : rx0;
        ry_lo = (ry0 < ry1) ? ry0 : ry1;
        ry_hi = (ry0 < ry1) ? ry1 : ry0;
    end

    // Command sequencer: dispatch popped commands and walk the raster
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        fill_d    = fill_q;
        pal_idx_d = pal_idx_q;
        pal_col_d = pal_col_q;
        err_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    case (head.op)
                        OP_CLEAR: begin
                            xmin_d  = '0;
                            xmax_d  = X_LAST;
                            ymin_d  = '0;
                            ymax_d  = Y_LAST;
                            x_d     = '0;
                            y_d     = '0;
                            fill_d  = head.idx;
                            state_d = S_RASTER;
                        end
                        OP_FILL: begin
                            if (rect_oob) begin
                                err_set = 1'b1;
                            end else begin
                                xmin_d  = rx_lo;
                                xmax_d  = rx_hi;
                                ymin_d  = ry_lo;
                                ymax_d  = ry_hi;
                                x_d     = rx_lo;
                                y_d     = ry_lo;
                                fill_d  = head.idx;
                                state_d = S_RASTER;
                            end
                        end
                        OP_PAL: begin
                            pal_idx_d = head.idx;
                            pal_col_d = head.color;
                            state_d   = S_PALETTE;
                        end
                        default: ;
                    endcase
                end
            end
            S_RASTER: begin
                if (fb_wr_ready_i) begin
                    if (x_q == xmax_q) begin
                        x_d = xmin_q;
                        if (y_q == ymax_q) state_d = S_IDLE;
                        else               y_d     = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_PALETTE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;

        error_d = error_q;
        if (control_i[1]) error_d = 1'b0;
        if (err_set)      error_d = 1'b1;
    end

    // Sequencer state registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            fill_q    <= '0;
            pal_idx_q <= '0;
            pal_col_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            fill_q    <= fill_d;
            pal_idx_q <= pal_idx_d;
            pal_col_q <= pal_col_d;
            error_q   <= error_d;
        end
    end

    assign fb_wr_en_o         = (state_q == S_RASTER);
    assign fb_wr_x_o          = x_q;
    assign fb_wr_y_o          = y_q;
    assign fb_wr_index_o      = fill_q;
    assign palette_wr_en_o    = (state_q == S_PALETTE);
    assign palette_wr_index_o = pal_idx_q;
    assign palette_wr_color_o = pal_col_q;

    assign status_o = {16'h0, 8'(count_q), 5'h0, full, error_q,
                       (state_q != S_IDLE) || (count_q != '0)};

endmodule

// File: tb/tb_raster_cmd_processor.sv
// Testbench for raster_cmd_processor: scenario tasks compared against a
// pixel-list model. A second instance with a 9-pixel-wide framebuffer
// exercises out-of-range FILL_RECT handling (RASTER_CLIP_EN aware).
module tb_raster_cmd_processor;

    localparam int RX = 8, RY = 4, RX2 = 9, RY2 = 4;

    typedef struct {int x; int y; int idx;} wr_t;
    typedef struct {int idx; int col; int cyc;} pal_t;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic [31:0] control_i = '0;
    logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cx0 = '0, cx1 = '0;
    logic [1:0]  cy0 = '0, cy1 = '0;
    logic [3:0]  cidx = '0;
    logic [11:0] ccol = '0;
    logic        fb_rdy = 1'b0;

    logic [31:0] status_o, status2;
    logic        cmd_ready, cmd_ready2;
    logic [2:0]  fb_x;
    logic [3:0]  fb2_x;
    logic [1:0]  fb_y, fb2_y;
    logic [3:0]  fb_idx, fb2_idx, pal_idx, unused_pal2_idx;
    logic [11:0] pal_col, unused_pal2_col;
    logic        fb_en, fb2_en, pal_en, unused_pal2_en;

    int   n_checks = 0, n_pass = 0, cyc = 0;
    bit   rnd_rdy = 1'b0;
    wr_t  wr_q[$], exp_q[$], wr2_q[$], exp2_q[$];
    pal_t pal_q[$];

    raster_cmd_processor #(.RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(16),
                           .COLOR_BITS(12), .CMD_FIFO_DEPTH(4)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .control_i(control_i), .status_o(status_o),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_x0_i(cx0[2:0]), .cmd_x1_i(cx1[2:0]), .cmd_y0_i(cy0), .cmd_y1_i(cy1),
        .cmd_index_i(cidx), .cmd_color_i(ccol),
        .fb_wr_x_o(fb_x), .fb_wr_y_o(fb_y), .fb_wr_index_o(fb_idx), .fb_wr_en_o(fb_en),
        .fb_wr_ready_i(fb_rdy), .palette_wr_index_o(pal_idx),
        .palette_wr_color_o(pal_col), .palette_wr_en_o(pal_en));

    raster_cmd_processor #(.RESOLUTION_X(RX2), .RESOLUTION_Y(RY2), .PALETTE_LENGTH(16),
                           .COLOR_BITS(12), .CMD_FIFO_DEPTH(4)) dut2 (
        .clk_i(clk), .reset_ni(reset_ni), .control_i(control_i), .status_o(status2),
        .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_op_i(cmd_op),
        .cmd_x0_i(cx0), .cmd_x1_i(cx1), .cmd_y0_i(cy0), .cmd_y1_i(cy1),
        .cmd_index_i(cidx), .cmd_color_i(ccol),
        .fb_wr_x_o(fb2_x), .fb_wr_y_o(fb2_y), .fb_wr_index_o(fb2_idx), .fb_wr_en_o(fb2_en),
        .fb_wr_ready_i(fb_rdy), .palette_wr_index_o(unused_pal2_idx),
        .palette_wr_color_o(unused_pal2_col), .palette_wr_en_o(unused_pal2_en));

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Random framebuffer back-pressure when enabled
    always @(posedge clk) if (rnd_rdy) begin
        #1 fb_rdy = ($urandom_range(0, 3) != 0);
    end

    // Record accepted pixel writes and palette pulses away from the edge
    always @(negedge clk) begin : capture
        wr_t  w;
        pal_t p;
        if (fb_en && fb_rdy) begin
            w.x = int'(fb_x); w.y = int'(fb_y); w.idx = int'(fb_idx); wr_q.push_back(w);
        end
        if (fb2_en && fb_rdy) begin
            w.x = int'(fb2_x); w.y = int'(fb2_y); w.idx = int'(fb2_idx); wr2_q.push_back(w);
        end
        if (pal_en) begin
            p.idx = int'(pal_idx); p.col = int'(pal_col); p.cyc = cyc; pal_q.push_back(p);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Reference model: pixel list of a rectangle in raster order
    task automatic model_fill(input int x0, input int y0, input int x1, input int y1,
                              input int idx, input int rx, input int ry, input bit to2);
        wr_t e;
        int  xl, xh, yl, yh;
`ifdef RASTER_CLIP_EN
        if (x0 > rx - 1) x0 = rx - 1;
        if (x1 > rx - 1) x1 = rx - 1;
        if (y0 > ry - 1) y0 = ry - 1;
        if (y1 > ry - 1) y1 = ry - 1;
`else
        if (x0 >= rx || x1 >= rx || y0 >= ry || y1 >= ry) return;
`endif
        xl = (x0 < x1) ? x0 : x1; xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1; yh = (y0 < y1) ? y1 : y0;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                e.x = x; e.y = y; e.idx = idx;
                if (to2) exp2_q.push_back(e); else exp_q.push_back(e);
            end
    endtask

    function automatic int diff_q(input bit to2);
        wr_t a[$];
        wr_t b[$];
        int  n;
        if (to2) begin a = wr2_q; b = exp2_q; end
        else     begin a = wr_q;  b = exp_q;  end
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i].x != b[i].x || a[i].y != b[i].y || a[i].idx != b[i].idx) n++;
        return n;
    endfunction

    // Present one command and hold it until the handshake completes (bounded)
    task automatic push_cmd(input bit to2, input logic [1:0] op, input int x0, input int y0,
                            input int x1, input int y1, input int idx, input int col,
                            output bit ok);
        cmd_op = op; cx0 = 4'(x0); cx1 = 4'(x1); cy0 = 2'(y0); cy1 = 2'(y1);
        cidx = 4'(idx); ccol = 12'(col);
        cmd_valid = !to2; cmd_valid2 = to2; ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (to2 ? cmd_ready2 : cmd_ready) begin
                tick(); ok = 1'b1; break;
            end
            tick();
        end
        cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; fb_rdy = 1'b1;
        repeat (3) tick();
        n_checks++; if (status_o !== 32'h0) $display("FAIL reset_status: got %h want 0", status_o); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else n_pass++;
        n_checks++; if (fb_en !== 1'b0) $display("FAIL reset_fb_en: got %b want 0", fb_en); else n_pass++;
        n_checks++; if (pal_en !== 1'b0) $display("FAIL reset_pal_en: got %b want 0", pal_en); else n_pass++;
        n_checks++; if ({fb_x, fb_y, fb_idx} !== 9'h0) $display("FAIL reset_fb_data: got %h want 0", {fb_x, fb_y, fb_idx}); else n_pass++;
        n_checks++; if ({pal_idx, pal_col} !== 16'h0) $display("FAIL reset_pal_data: got %h want 0", {pal_idx, pal_col}); else n_pass++;
        cmd_valid = 1'b0; fb_rdy = 1'b0; reset_ni = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", cmd_ready); else n_pass++;
        n_checks++; if (status_o !== 32'h0) $display("FAIL post_reset_status: got %h want 0", status_o); else n_pass++;
        tick();
    endtask

    task automatic test_clear();
        bit ok, idle;
        int n;
        fb_rdy = 1'b1; wr_q.delete(); exp_q.delete(); idle = 1'b0;
        model_fill(0, 0, RX - 1, RY - 1, 5, RX, RY, 1'b0);
        push_cmd(1'b0, 2'd1, 0, 0, 0, 0, 5, 0, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL clear_accept: got %b want 1", ok); else n_pass++;
        @(negedge clk);
        n_checks++; if (fb_en !== 1'b0) $display("FAIL clear_latency_early: got %b want 0", fb_en); else n_pass++;
        tick(); @(negedge clk);
        n_checks++; if (fb_en !== 1'b1) $display("FAIL clear_latency: got %b want 1", fb_en); else n_pass++;
        n_checks++; if ({fb_x, fb_y, fb_idx} !== {3'd0, 2'd0, 4'd5}) $display("FAIL clear_first_px: got %h want %h", {fb_x, fb_y, fb_idx}, {3'd0, 2'd0, 4'd5}); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            tick(); @(negedge clk);
            if (!status_o[0]) begin idle = 1'b1; break; end
        end
        n_checks++; if (idle !== 1'b1) $display("FAIL clear_done: got busy=%b want 0", status_o[0]); else n_pass++;
        n = diff_q(1'b0);
        n_checks++; if (n !== 0) $display("FAIL clear_writes: got %0d mismatches (%0d writes) want 0 (%0d writes)", n, wr_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (wr_q.size() !== 32) $display("FAIL clear_count: got %0d want 32", wr_q.size()); else n_pass++;
        tick();
    endtask

    task automatic test_fill_rect();
        bit         ok, idle, hold;
        logic [8:0] held;
        int         n;
        fb_rdy = 1'b1; wr_q.delete(); exp_q.delete(); idle = 1'b0; hold = 1'b0; held = '0;
        model_fill(5, 2, 2, 1, 9, RX, RY, 1'b0);
        push_cmd(1'b0, 2'd2, 5, 2, 2, 1, 9, 0, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL fill_accept: got %b want 1", ok); else n_pass++;
        for (int i = 0; i < 200; i++) begin
            fb_rdy = ~fb_rdy;
            @(negedge clk);
            if (hold) begin
                n_checks++; if ({fb_x, fb_y, fb_idx} !== held) $display("FAIL fill_hold: got %h want %h", {fb_x, fb_y, fb_idx}, held); else n_pass++;
            end
            hold = fb_en && !fb_rdy; held = {fb_x, fb_y, fb_idx};
            if (!status_o[0]) begin idle = 1'b1; break; end
            tick();
        end
        n_checks++; if (idle !== 1'b1) $display("FAIL fill_done: got busy=%b want 0", status_o[0]); else n_pass++;
        n = diff_q(1'b0);
        n_checks++; if (n !== 0) $display("FAIL fill_writes: got %0d mismatches (%0d writes) want 0 (%0d writes)", n, wr_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (wr_q.size() !== 8) $display("FAIL fill_count: got %0d want 8", wr_q.size()); else n_pass++;
        fb_rdy = 1'b1;
        tick();
    endtask

    task automatic test_palette();
        bit ok;
        int acc;
        pal_q.delete();
        push_cmd(1'b0, 2'd3, 0, 0, 0, 0, 3, 12'hABC, ok);
        acc = cyc;
        repeat (5) tick();
        n_checks++; if (ok !== 1'b1) $display("FAIL pal_accept: got %b want 1", ok); else n_pass++;
        n_checks++; if (pal_q.size() !== 1) $display("FAIL pal_pulses: got %0d want 1", pal_q.size()); else n_pass++;
        if (pal_q.size() > 0) begin
            n_checks++; if (pal_q[0].idx !== 3) $display("FAIL pal_index: got %0d want 3", pal_q[0].idx); else n_pass++;
            n_checks++; if (pal_q[0].col !== 32'hABC) $display("FAIL pal_color: got %h want abc", pal_q[0].col); else n_pass++;
            n_checks++; if (pal_q[0].cyc !== acc + 1) $display("FAIL pal_latency: got cycle %0d want %0d", pal_q[0].cyc, acc + 1); else n_pass++;
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        fb_rdy = 1'b0; wr_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'b0, 2'd1, 0, 0, 0, 0, i, 0, ok);
            n_checks++; if (ok !== 1'b1) $display("FAIL full_push%0d: got %b want 1", i, ok); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", cmd_ready); else n_pass++;
        n_checks++; if (status_o[2] !== 1'b1) $display("FAIL full_flag: got %b want 1", status_o[2]); else n_pass++;
        n_checks++; if (status_o[15:8] !== 8'd4) $display("FAIL full_count: got %0d want 4", status_o[15:8]); else n_pass++;
        n_checks++; if (status_o[0] !== 1'b1) $display("FAIL full_busy: got %b want 1", status_o[0]); else n_pass++;
        tick();
        control_i = 32'h1; tick(); control_i = 32'h0;
        @(negedge clk);
        n_checks++; if (status_o !== 32'h0) $display("FAIL full_flush_status: got %h want 0", status_o); else n_pass++;
        fb_rdy = 1'b1;
        repeat (50) tick();
        n_checks++; if (wr_q.size() !== 0) $display("FAIL full_flush_writes: got %0d want 0", wr_q.size()); else n_pass++;
    endtask

    task automatic test_abort();
        bit ok1, ok2, ok3;
        fb_rdy = 1'b1;
        push_cmd(1'b0, 2'd1, 0, 0, 0, 0, 7, 0, ok1);
        push_cmd(1'b0, 2'd2, 0, 0, 1, 1, 2, 0, ok2);
        push_cmd(1'b0, 2'd2, 2, 2, 3, 3, 3, 0, ok3);
        n_checks++; if ({ok1, ok2, ok3} !== 3'b111) $display("FAIL abort_setup: got %b want 111", {ok1, ok2, ok3}); else n_pass++;
        tick();
        control_i = 32'h1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", cmd_ready); else n_pass++;
        n_checks++; if (fb_en !== 1'b1) $display("FAIL abort_running: got %b want 1", fb_en); else n_pass++;
        tick(); control_i = 32'h0; wr_q.delete(); pal_q.delete();
        @(negedge clk);
        n_checks++; if (fb_en !== 1'b0) $display("FAIL abort_fb_en: got %b want 0", fb_en); else n_pass++;
        n_checks++; if (status_o[15:8] !== 8'd0) $display("FAIL abort_count: got %0d want 0", status_o[15:8]); else n_pass++;
        n_checks++; if (status_o[0] !== 1'b0) $display("FAIL abort_busy: got %b want 0", status_o[0]); else n_pass++;
        repeat (50) tick();
        n_checks++; if (wr_q.size() + pal_q.size() !== 0) $display("FAIL abort_leftover: got %0d writes want 0", wr_q.size() + pal_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        fb_rdy = 1'b1;
        push_cmd(1'b0, 2'd1, 0, 0, 0, 0, 4, 0, ok);
        repeat (4) tick();
        reset_ni = 1'b0; #1;
        n_checks++; if (fb_en !== 1'b0) $display("FAIL midreset_fb_en: got %b want 0", fb_en); else n_pass++;
        n_checks++; if (status_o !== 32'h0) $display("FAIL midreset_status: got %h want 0", status_o); else n_pass++;
        tick(); reset_ni = 1'b1; wr_q.delete();
        repeat (40) tick();
        n_checks++; if (wr_q.size() !== 0) $display("FAIL midreset_writes: got %0d want 0", wr_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        bit ok, all_ok, idle;
        int n;
        wr_q.delete(); exp_q.delete(); all_ok = 1'b1; idle = 1'b0; rnd_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int x0, y0, x1, y1, idx;
            x0 = $urandom_range(0, RX - 1); x1 = $urandom_range(0, RX - 1);
            y0 = $urandom_range(0, RY - 1); y1 = $urandom_range(0, RY - 1);
            idx = $urandom_range(0, 15);
            model_fill(x0, y0, x1, y1, idx, RX, RY, 1'b0);
            push_cmd(1'b0, 2'd2, x0, y0, x1, y1, idx, 0, ok);
            all_ok &= ok;
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!status_o[0]) begin idle = 1'b1; break; end
            @(posedge clk);
        end
        rnd_rdy = 1'b0;
        tick(); fb_rdy = 1'b1;
        n_checks++; if (all_ok !== 1'b1) $display("FAIL rand_accept: got %b want 1", all_ok); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rand_done: got busy=%b want 0", status_o[0]); else n_pass++;
        n = diff_q(1'b0);
        n_checks++; if (n !== 0) $display("FAIL rand_writes: got %0d mismatches (%0d writes) want 0 (%0d writes)", n, wr_q.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_out_of_range();
        bit ok, idle;
        int n;
        fb_rdy = 1'b1; wr2_q.delete(); exp2_q.delete(); idle = 1'b0;
        model_fill(0, 0, 9, 1, 6, RX2, RY2, 1'b1);
        push_cmd(1'b1, 2'd2, 0, 0, 9, 1, 6, 0, ok);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!status2[0]) begin idle = 1'b1; break; end
            tick();
        end
        tick();
        n_checks++; if ({ok, idle} !== 2'b11) $display("FAIL oor_run: got %b want 11", {ok, idle}); else n_pass++;
        n = diff_q(1'b1);
        n_checks++; if (n !== 0) $display("FAIL oor_writes: got %0d mismatches (%0d writes) want 0 (%0d writes)", n, wr2_q.size(), exp2_q.size()); else n_pass++;
`ifdef RASTER_CLIP_EN
        n_checks++; if (wr2_q.size() !== 18) $display("FAIL oor_clip_count: got %0d want 18", wr2_q.size()); else n_pass++;
        n_checks++; if (status2[1] !== 1'b0) $display("FAIL oor_clip_error: got %b want 0", status2[1]); else n_pass++;
`else
        n_checks++; if (wr2_q.size() !== 0) $display("FAIL oor_count: got %0d want 0", wr2_q.size()); else n_pass++;
        n_checks++; if (status2[1] !== 1'b1) $display("FAIL oor_error: got %b want 1", status2[1]); else n_pass++;
        control_i = 32'h2; tick(); control_i = 32'h0;
        @(negedge clk);
        n_checks++; if (status2[1] !== 1'b0) $display("FAIL oor_error_clear: got %b want 0", status2[1]); else n_pass++;
        tick();
        push_cmd(1'b1, 2'd2, 9, 0, 0, 1, 6, 0, ok);
        control_i = 32'h2; tick(); control_i = 32'h0;
        @(negedge clk);
        n_checks++; if ({ok, status2[1]} !== 2'b11) $display("FAIL oor_error_wins: got %b want 11", {ok, status2[1]}); else n_pass++;
        tick();
        control_i = 32'h2; tick(); control_i = 32'h0;
`endif
    endtask

    initial begin
        test_reset();
        test_clear();
        test_fill_rect();
        test_palette();
        test_fifo_full();
        test_abort();
        test_reset_mid();
        test_back_to_back_random();
        test_out_of_range();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
